// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, reads a combinational instruction
// memory, buffers {pc, instr} pairs in a small FIFO and hands them to decode
// over a valid/ready handshake. Handles redirect/flush, fetch enable and a
// sticky halt on a misaligned redirect target.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        misaligned_err
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [31:0]       fetch_pc;
  logic [31:0]       pc_mem    [FIFO_DEPTH];
  logic [31:0]       instr_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [31:0]       hold_pc, hold_instr;

  logic              bad_target;
  logic              enter_halt;
  logic              flush;
  logic              push;
  logic              pop;
  logic              full;

  assign imem_pc    = fetch_pc;
  assign full       = (count == FULL_CNT);
  assign out_valid  = (count != '0);
  assign bad_target = redirect_valid && (redirect_pc[1:0] != 2'b00);

  // Head entry when non-empty; otherwise the last head that was presented.
  assign out_pc    = out_valid ? pc_mem[rd_ptr]    : hold_pc;
  assign out_instr = out_valid ? instr_mem[rd_ptr] : hold_instr;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state and per-cycle control decode; misaligned redirect outranks the
  // aligned one, which in turn suppresses both push and pop.
  always_comb begin
    state_nx   = state;
    enter_halt = 1'b0;
    flush      = 1'b0;
    push       = 1'b0;
    unique case (state)
      IDLE: begin
        if (bad_target) begin
          enter_halt = 1'b1;
          state_nx   = HALT;
        end else begin
          flush = redirect_valid;
          if (fetch_en) state_nx = RUN;
        end
      end
      RUN: begin
        if (bad_target) begin
          enter_halt = 1'b1;
          state_nx   = HALT;
        end else if (redirect_valid) begin
          flush = 1'b1;
          if (!fetch_en) state_nx = IDLE;
        end else if (!fetch_en) begin
          state_nx = IDLE;
        end else begin
          push = !full;
        end
      end
      HALT: begin
        state_nx = HALT;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    pop = out_valid && out_ready && !flush;
  end

  // Program counter and sticky misalignment flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc       <= RESET_PC;
      misaligned_err <= 1'b0;
    end else begin
      if (enter_halt) misaligned_err <= 1'b1;
      if (flush)      fetch_pc <= redirect_pc;
      else if (push)  fetch_pc <= fetch_pc + 32'd4;
    end
  end

  // FIFO storage; only written on a push.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      pc_mem[wr_ptr]    <= fetch_pc;
      instr_mem[wr_ptr] <= imem_instr;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Remember the presented head so outputs stay put once the FIFO drains.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_pc    <= '0;
      hold_instr <= '0;
    end else if (out_valid) begin
      hold_pc    <= pc_mem[rd_ptr];
      hold_instr <= instr_mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a queue of expected fetch PCs is
// loaded whenever the stream (re)starts and popped on every handshake.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_ready;

  logic [31:0] imem_pc,  imem_instr,  out_instr,  out_pc;
  logic        out_valid,  misaligned_err;
  logic [31:0] imem_pc2, imem_instr2, out_instr2, out_pc2;
  logic        out_valid2, misaligned_err2;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [31:0] exp_q[$];
  logic        sb_on = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   mem_word = 32'h0050_0093;
      32'h4:   mem_word = 32'h00A0_0113;
      32'h8:   mem_word = 32'h0020_81B3;
      default: mem_word = a ^ 32'h1357_9BDF;
    endcase
  endfunction

  assign imem_instr  = mem_word(imem_pc);
  assign imem_instr2 = mem_word(imem_pc2);

  fetch_sequencer dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en),
    .imem_pc(imem_pc), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .misaligned_err(misaligned_err)
  );

  fetch_sequencer #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .reset(reset), .fetch_en(fetch_en),
    .imem_pc(imem_pc2), .imem_instr(imem_instr2),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_instr(out_instr2), .out_pc(out_pc2),
    .misaligned_err(misaligned_err2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic sb_restart(input logic [31:0] base);
    exp_q.delete();
    for (int unsigned i = 0; i < 24; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  // Called just after a falling edge with inputs set: score the handshake
  // that the coming rising edge will perform, then advance one cycle.
  task automatic step();
    logic [31:0] e;
    if (sb_on && !reset && !redirect_valid && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_pc", out_pc, e);
        check("sb_instr", out_instr, mem_word(e));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [31:0] base);
    reset = 1'b1;
    step();
    reset = 1'b0;
    sb_restart(base);
  endtask

  initial begin
    reset = 1'b1; fetch_en = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    @(negedge clk);
    step(); step();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_instr", out_instr, 32'd0);
    check("rst_pc", out_pc, 32'd0);
    check("rst_imem_pc", imem_pc, 32'd0);
    check("rst_err", 32'(misaligned_err), 32'd0);
    check("rst_imem_pc_wrap", imem_pc2, 32'hFFFF_FFF8);

    // 1: basic streaming latency and throughput
    reset = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
    sb_restart(32'h0); sb_on = 1'b1;
    step();
    check("t1_valid_c1", 32'(out_valid), 32'd0);
    step();
    check("t1_valid_c2", 32'(out_valid), 32'd1);
    check("t1_first_pc", out_pc, 32'h0);
    check("t1_first_instr", out_instr, 32'h0050_0093);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t1_stream_valid", 32'(out_valid), 32'd1);
    end

    // 2: backpressure from the start
    out_ready = 1'b0;
    do_reset(32'h0);
    step(); step(); step(); step();
    check("t2_imem_hold", imem_pc, 32'h8);
    check("t2_head_pc", out_pc, 32'h0);
    check("t2_valid", 32'(out_valid), 32'd1);
    step();
    check("t2_imem_hold2", imem_pc, 32'h8);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();

    // 3: aligned redirect with a full FIFO
    out_ready = 1'b0;
    step(); step(); step();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    redirect_valid = 1'b0;
    sb_restart(32'h40);
    check("t3_flush_valid", 32'(out_valid), 32'd0);
    step();
    check("t3_redir_valid", 32'(out_valid), 32'd1);
    check("t3_redir_pc", out_pc, 32'h40);
    check("t3_redir_instr", out_instr, mem_word(32'h40));
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // 4: misaligned redirect halts; later redirects ignored
    out_ready = 1'b0;
    do_reset(32'h0);
    step(); step(); step(); step();
    check("t4_pre_imem", imem_pc, 32'h8);
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    step();
    check("t4_err_set", 32'(misaligned_err), 32'd1);
    check("t4_imem_frozen", imem_pc, 32'h8);
    redirect_pc = 32'h80;
    step();
    redirect_valid = 1'b0;
    check("t4_ignore_redir_imem", imem_pc, 32'h8);
    check("t4_ignore_redir_head", out_pc, 32'h0);
    step(); step();
    check("t4_halt_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    step(); step(); step();
    check("t4_drained", 32'(out_valid), 32'd0);
    check("t4_hold_pc", out_pc, 32'h4);
    check("t4_imem_end", imem_pc, 32'h8);
    check("t4_err_sticky", 32'(misaligned_err), 32'd1);

    // 6: reset clears error and mid-stream entries; fetch_en gating
    out_ready = 1'b0;
    do_reset(32'h0);
    check("t6_err_clr", 32'(misaligned_err), 32'd0);
    check("t6_out_pc_clr", out_pc, 32'd0);
    step(); step(); step();
    check("t6_pre_valid", 32'(out_valid), 32'd1);
    do_reset(32'h0);
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_imem", imem_pc, 32'h0);
    check("t6_rst_err", 32'(misaligned_err), 32'd0);
    step(); step();
    fetch_en = 1'b0;
    step();
    check("t6_en_off_imem", imem_pc, 32'h4);
    step(); step();
    check("t6_en_off_imem2", imem_pc, 32'h4);
    check("t6_en_off_valid", 32'(out_valid), 32'd1);
    check("t6_en_off_pc", out_pc, 32'h0);
    out_ready = 1'b1;
    step();
    check("t6_no_growth", 32'(out_valid), 32'd0);
    check("t6_hold_pc", out_pc, 32'h0);

    // 5: PC wrap-around on the high-RESET_PC instance
    fetch_en = 1'b1; out_ready = 1'b1;
    do_reset(32'h0);
    step();
    check("t5_valid_c1", 32'(out_valid2), 32'd0);
    step();
    check("t5_valid_c2", 32'(out_valid2), 32'd1);
    check("t5_pc0", out_pc2, 32'hFFFF_FFF8);
    check("t5_instr0", out_instr2, mem_word(32'hFFFF_FFF8));
    step();
    check("t5_pc1", out_pc2, 32'hFFFF_FFFC);
    step();
    check("t5_pc2", out_pc2, 32'h0000_0000);
    check("t5_instr2", out_instr2, 32'h0050_0093);
    step();
    check("t5_pc3", out_pc2, 32'h0000_0004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
